// File: rtl/ram_bus_sequencer_pkg.sv
// Shared definitions for the RAM bus sequencer: state encodings, owner codes
// and default DRAM timing constants.
package ram_bus_sequencer_pkg;

  // Default timing, in c16m cycles.
  localparam int unsigned TRcdDefault = 2;
  localparam int unsigned TCasDefault = 2;
  localparam int unsigned TRpDefault  = 2;
  // Phase timer width; must hold max(T_*) - 1.
  localparam int unsigned CwDefault   = 3;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRas  = 3'd1,
    StCas  = 3'd2,
    StPre  = 3'd3,
    StHold = 3'd4
  } state_e;

  typedef enum logic {
    OwnCpu = 1'b0,
    OwnDma = 1'b1
  } owner_e;

endpackage

// File: rtl/ram_bus_sequencer_phase_timer.sv
// Phase timer for the RAM bus sequencer: a CW-bit up-counter with synchronous
// clear and a terminal-count compare against a programmable limit.
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   clr_i    synchronous clear (wins over en_i)
//   en_i     count enable
//   limit_i  terminal count value
//   count_o  current count
//   tc_o     count_o == limit_i
module ram_bus_sequencer_phase_timer #(
  parameter int unsigned CW = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] limit_i,
  output logic [CW-1:0] count_o,
  output logic          tc_o
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == limit_i);

endmodule

// File: rtl/ram_bus_sequencer.sv
// RAM bus sequencer: time-shares the DRAM and its ls245 data transceiver
// between the 68000 CPU and the video/sound DMA fetch engine.
//   c16m         16 MHz master clock (rising edge)
//   n_res        asynchronous active-low reset
//   cpu_n_as     CPU address strobe (synchronous to c16m)
//   cpu_r_nw     CPU read (1) / write (0)
//   cpu_ram_sel  address decode hit on RAM
//   dma_req      DMA fetch request (level)
//   cpu_n_dtack  data acknowledge to the CPU
//   dma_ack      one-cycle pulse when the DMA word is complete
//   dma_latch    DMA data latch strobe (final CAS cycle)
//   dma_owns     address mux owner select (1 = DMA)
//   addr_sel     address mux row (0) / column (1)
//   n_ras/n_cas  DRAM strobes
//   ram_n_we     DRAM write enable
//   buf_n_oe     ls245 /OE
//   buf_dir      ls245 DIR (1 = CPU to RAM)
// All outputs are registered.
module ram_bus_sequencer
  import ram_bus_sequencer_pkg::*;
#(
  parameter int unsigned T_RCD = TRcdDefault,
  parameter int unsigned T_CAS = TCasDefault,
  parameter int unsigned T_RP  = TRpDefault,
  parameter int unsigned CW    = CwDefault
) (
  input  logic c16m,
  input  logic n_res,
  input  logic cpu_n_as,
  input  logic cpu_r_nw,
  input  logic cpu_ram_sel,
  input  logic dma_req,
  output logic cpu_n_dtack,
  output logic dma_ack,
  output logic dma_latch,
  output logic dma_owns,
  output logic addr_sel,
  output logic n_ras,
  output logic n_cas,
  output logic ram_n_we,
  output logic buf_n_oe,
  output logic buf_dir
);

  localparam logic [CW-1:0] RcdLast   = CW'(T_RCD - 1);
  localparam logic [CW-1:0] CasLast   = CW'(T_CAS - 1);
  localparam logic [CW-1:0] RpLast    = CW'(T_RP - 1);
  // Count value one before the final CAS cycle (only meaningful for T_CAS > 1).
  localparam logic [CW-1:0] CasPenult = CW'((T_CAS > 1) ? (T_CAS - 2) : 0);

  state_e state_q, state_d;
  owner_e last_grant_q, last_grant_d;

  logic cpu_n_dtack_q, cpu_n_dtack_d;
  logic dma_ack_q, dma_ack_d;
  logic dma_latch_q, dma_latch_d;
  logic dma_owns_q, dma_owns_d;
  logic addr_sel_q, addr_sel_d;
  logic n_ras_q, n_ras_d;
  logic n_cas_q, n_cas_d;
  logic ram_n_we_q, ram_n_we_d;
  logic buf_n_oe_q, buf_n_oe_d;
  logic buf_dir_q, buf_dir_d;

  logic          cpu_req;
  logic          cpu_owner;
  logic          grant_dma;
  logic          timer_clr;
  logic          timer_en;
  logic          timer_tc;
  logic [CW-1:0] timer_limit;
  logic [CW-1:0] timer_count;

  assign cpu_req   = ~cpu_n_as & cpu_ram_sel;
  assign cpu_owner = ~dma_owns_q;

  always_comb begin
    unique case (state_q)
      StRas:   timer_limit = RcdLast;
      StCas:   timer_limit = CasLast;
      StPre:   timer_limit = RpLast;
      default: timer_limit = '0;
    endcase
  end

  // Timer restarts on every state change and only runs in timed states.
  assign timer_clr = (state_d != state_q);
  assign timer_en  = (state_q == StRas) || (state_q == StCas) || (state_q == StPre);

  ram_bus_sequencer_phase_timer #(
    .CW(CW)
  ) u_timer (
    .clk_i   (c16m),
    .rst_ni  (n_res),
    .clr_i   (timer_clr),
    .en_i    (timer_en),
    .limit_i (timer_limit),
    .count_o (timer_count),
    .tc_o    (timer_tc)
  );

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cpu_n_dtack_d = cpu_n_dtack_q;
    dma_ack_d     = 1'b0;
    dma_latch_d   = 1'b0;
    dma_owns_d    = dma_owns_q;
    addr_sel_d    = addr_sel_q;
    n_ras_d       = n_ras_q;
    n_cas_d       = n_cas_q;
    ram_n_we_d    = ram_n_we_q;
    buf_n_oe_d    = buf_n_oe_q;
    buf_dir_d     = buf_dir_q;
    grant_dma     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dma_req || cpu_req) begin
          // Round-robin on a tie: the requester that did not win last time.
          grant_dma    = dma_req && (!cpu_req || (last_grant_q == OwnCpu));
          state_d      = StRas;
          n_ras_d      = 1'b0;
          dma_owns_d   = grant_dma;
          last_grant_d = grant_dma ? OwnDma : OwnCpu;
          if (!grant_dma) begin
            buf_n_oe_d = 1'b0;
            buf_dir_d  = ~cpu_r_nw;
          end
        end
      end

      StRas: begin
        if (timer_tc) begin
          state_d    = StCas;
          addr_sel_d = 1'b1;
          n_cas_d    = 1'b0;
          // buf_dir_q was captured at grant and marks a CPU write.
          ram_n_we_d = ~(cpu_owner & buf_dir_q);
          if (!cpu_owner && (T_CAS == 1)) begin
            dma_latch_d = 1'b1;
          end
        end
      end

      StCas: begin
        if (timer_tc) begin
          state_d    = StPre;
          n_ras_d    = 1'b1;
          n_cas_d    = 1'b1;
          ram_n_we_d = 1'b1;
          addr_sel_d = 1'b0;
          if (cpu_owner) begin
            cpu_n_dtack_d = 1'b0;
          end else begin
            dma_ack_d = 1'b1;
          end
        end else if (!cpu_owner && (timer_count == CasPenult)) begin
          // Registered, so set one edge early to land on the final CAS cycle.
          dma_latch_d = 1'b1;
        end
      end

      StPre: begin
        if (cpu_owner && cpu_n_as) begin
          cpu_n_dtack_d = 1'b1;
          buf_n_oe_d    = 1'b1;
        end
        if (timer_tc) begin
          if (!cpu_owner) begin
            state_d    = StIdle;
            dma_owns_d = 1'b0;
          end else if (cpu_n_as) begin
            state_d = StIdle;
          end else begin
            state_d = StHold;
          end
        end
      end

      StHold: begin
        if (cpu_n_as) begin
          cpu_n_dtack_d = 1'b1;
          buf_n_oe_d    = 1'b1;
          state_d       = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge c16m or negedge n_res) begin
    if (!n_res) begin
      state_q       <= StIdle;
      last_grant_q  <= OwnCpu;
      cpu_n_dtack_q <= 1'b1;
      dma_ack_q     <= 1'b0;
      dma_latch_q   <= 1'b0;
      dma_owns_q    <= 1'b0;
      addr_sel_q    <= 1'b0;
      n_ras_q       <= 1'b1;
      n_cas_q       <= 1'b1;
      ram_n_we_q    <= 1'b1;
      buf_n_oe_q    <= 1'b1;
      buf_dir_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cpu_n_dtack_q <= cpu_n_dtack_d;
      dma_ack_q     <= dma_ack_d;
      dma_latch_q   <= dma_latch_d;
      dma_owns_q    <= dma_owns_d;
      addr_sel_q    <= addr_sel_d;
      n_ras_q       <= n_ras_d;
      n_cas_q       <= n_cas_d;
      ram_n_we_q    <= ram_n_we_d;
      buf_n_oe_q    <= buf_n_oe_d;
      buf_dir_q     <= buf_dir_d;
    end
  end

  assign cpu_n_dtack = cpu_n_dtack_q;
  assign dma_ack     = dma_ack_q;
  assign dma_latch   = dma_latch_q;
  assign dma_owns    = dma_owns_q;
  assign addr_sel    = addr_sel_q;
  assign n_ras       = n_ras_q;
  assign n_cas       = n_cas_q;
  assign ram_n_we    = ram_n_we_q;
  assign buf_n_oe    = buf_n_oe_q;
  assign buf_dir     = buf_dir_q;

endmodule
